clock_mode_ctrl: RTL



---
 rtl/clock_mode_ctrl_pkg.sv | 23 ++
 rtl/clock_mode_ctrl_if.sv | 24 ++
 rtl/clock_mode_ctrl_btn_edge.sv | 23 ++
 rtl/clock_mode_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// clock_mode_ctrl_pkg: state encodings, display-mode constants and state decode helpers
package clock_mode_ctrl_pkg;
  typedef enum logic [2:0] {
    CLK_RUN  = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    SW_IDLE  = 3'd4,
    SW_RUN   = 3'd5,
    SW_PAUSE = 3'd6
  } state_e;
  localparam logic MODE_CLK = 1'b0;
  localparam logic MODE_SW  = 1'b1;
  function automatic logic is_set(state_e s);
    return s inside {SET_HOUR, SET_MIN, SET_SEC};
  endfunction
  function automatic logic is_sw(state_e s);
    return s inside {SW_IDLE, SW_RUN, SW_PAUSE};
  endfunction
  function automatic logic [2:0] field_of(state_e s);
    return s == SET_HOUR ? 3'b100 : s == SET_MIN ? 3'b010 : s == SET_SEC ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: tick/button inputs and display/counter controls of the clock mode controller
interface clock_mode_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_set;
  logic       btn_inc;
  logic       btn_ss;
  logic       mode;
  logic       clk_en;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic [2:0] blink;
  logic       sw_en;
  logic       sw_clr;
  modport master (
    output tick_1hz, btn_mode, btn_set, btn_inc, btn_ss,
    input  mode, clk_en, inc_hour, inc_min, inc_sec, blink, sw_en, sw_clr
  );
  modport slave (
    input  tick_1hz, btn_mode, btn_set, btn_inc, btn_ss,
    output mode, clk_en, inc_hour, inc_min, inc_sec, blink, sw_en, sw_clr
  );
endinterface

// File: rtl/clock_mode_ctrl_btn_edge.sv
// clock_mode_ctrl_btn_edge: registered one-cycle rising-edge event from a debounced button level
module clock_mode_ctrl_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);
  logic prev_q, arm_q, evt_q, evt_d;
  // arm_q masks the first clock so a button held through reset release is not an event
  always_comb evt_d = btn & ~prev_q & arm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= btn;
      arm_q  <= 1'b1;
      evt_q  <= evt_d;
    end
  end
  assign evt = evt_q;
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: button/tick sequencing for clock display, time set and stopwatch control
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int SET_TIMEOUT = 10
) (
  input logic             clk,
  input logic             rst_n,
  clock_mode_ctrl_if.slave bus
);
  localparam int TW = $clog2(SET_TIMEOUT + 1);
  logic e_mode, e_set, e_inc, e_ss;
  clock_mode_ctrl_btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn(bus.btn_mode), .evt(e_mode));
  clock_mode_ctrl_btn_edge u_set  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_set),  .evt(e_set));
  clock_mode_ctrl_btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_inc),  .evt(e_inc));
  clock_mode_ctrl_btn_edge u_ss   (.clk(clk), .rst_n(rst_n), .btn(bus.btn_ss),   .evt(e_ss));
  state_e          state_q, state_d;
  logic [TW-1:0]   to_q, to_d;
  logic            mode_q, mode_d, clk_en_q, clk_en_d, sw_en_q, sw_en_d, sw_clr_q, sw_clr_d;
  logic [2:0]      inc_q, inc_d, blink_q, blink_d;
  logic            any_evt;
  assign any_evt = e_mode | e_set | e_inc | e_ss;
  always_comb begin
    state_d  = state_q;
    to_d     = '0;
    inc_d    = 3'b000;
    sw_clr_d = 1'b0;
    unique case (state_q)
      CLK_RUN:
        state_d = e_mode ? SW_IDLE : e_set ? SET_HOUR : CLK_RUN;
      SET_HOUR, SET_MIN, SET_SEC: begin
        to_d = any_evt ? '0 : to_q + TW'(bus.tick_1hz);
        if (e_set)
          state_d = state_q == SET_SEC ? CLK_RUN : state_e'(state_q + 3'd1);
        else if (e_inc)
          inc_d = field_of(state_q);
        else if (to_d == TW'(SET_TIMEOUT))
          state_d = CLK_RUN;
      end
      SW_IDLE:
        state_d = e_mode ? CLK_RUN : e_ss ? SW_RUN : SW_IDLE;
      SW_RUN:
        state_d = e_mode ? CLK_RUN : e_ss ? SW_PAUSE : SW_RUN;
      SW_PAUSE: begin
        state_d  = e_mode ? CLK_RUN : e_ss ? SW_RUN : e_inc ? SW_IDLE : SW_PAUSE;
        sw_clr_d = ~e_mode & ~e_ss & e_inc;
      end
      default:
        state_d = CLK_RUN;
    endcase
    // enables are gated by the state the tick arrived in, not the one being entered
    clk_en_d = bus.tick_1hz & ~is_set(state_q);
    sw_en_d  = bus.tick_1hz & (state_q == SW_RUN);
    mode_d   = is_sw(state_d) ? MODE_SW : MODE_CLK;
    blink_d  = field_of(state_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLK_RUN;
      to_q     <= '0;
      mode_q   <= MODE_CLK;
      clk_en_q <= 1'b0;
      sw_en_q  <= 1'b0;
      sw_clr_q <= 1'b0;
      inc_q    <= 3'b000;
      blink_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      mode_q   <= mode_d;
      clk_en_q <= clk_en_d;
      sw_en_q  <= sw_en_d;
      sw_clr_q <= sw_clr_d;
      inc_q    <= inc_d;
      blink_q  <= blink_d;
    end
  end
  assign bus.mode     = mode_q;
  assign bus.clk_en   = clk_en_q;
  assign bus.sw_en    = sw_en_q;
  assign bus.sw_clr   = sw_clr_q;
  assign bus.inc_hour = inc_q[2];
  assign bus.inc_min  = inc_q[1];
  assign bus.inc_sec  = inc_q[0];
  assign bus.blink    = blink_q;
endmodule
